// File: rtl/serial_add5bit_if.sv
// Operand/result bundle for serial_add5bit.
// The cout signal exists only when SADD_COUT_EN is defined.
interface serial_add5bit_if #(
    parameter int unsigned WIDTH = 5
);
    logic             start;
    logic [WIDTH-1:0] F;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
`ifdef SADD_COUT_EN
    logic             cout;

    // Requester side: issues operands, observes status and result
    modport master (output start, F, B, input busy, done, S, cout);
    // Adder side
    modport slave  (input start, F, B, output busy, done, S, cout);
`else
    // Requester side: issues operands, observes status and result
    modport master (output start, F, B, input busy, done, S);
    // Adder side
    modport slave  (input start, F, B, output busy, done, S);
`endif
endinterface

// File: rtl/serial_add5bit.sv
// Bit-serial adder S = F + B (mod 2^WIDTH), one bit per clock, LSB first.
// Optional feature macro: SADD_COUT_EN adds a registered final carry-out.
module serial_add5bit #(
    parameter int unsigned WIDTH = 5
) (
    input  logic            clk,
    input  logic            rst,
    serial_add5bit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] f_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_q;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             busy_q;
    logic             done_q;
    logic             bit_sum;
    logic             bit_carry;
`ifdef SADD_COUT_EN
    logic             cout_q;
`endif

    // Single full-adder slice on the current LSBs of the operand shifters
    always_comb begin
        bit_sum   = f_sh[0] ^ b_sh[0] ^ carry;
        bit_carry = (f_sh[0] & b_sh[0]) | (f_sh[0] & carry) | (b_sh[0] & carry);
    end

    // Control FSM plus datapath; busy/done are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            f_sh   <= '0;
            b_sh   <= '0;
            s_q    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
`ifdef SADD_COUT_EN
            cout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        f_sh   <= bus.F;
                        b_sh   <= bus.B;
                        s_q    <= '0;
                        cnt    <= '0;
                        carry  <= 1'b0;
`ifdef SADD_COUT_EN
                        cout_q <= 1'b0;
`endif
                        state  <= SHIFT;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    s_q   <= {bit_sum, s_q[WIDTH-1:1]};
                    carry <= bit_carry;
                    f_sh  <= f_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    // Leave SHIFT on the last bit so the counter never wraps
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
`ifdef SADD_COUT_EN
                        cout_q <= bit_carry;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.S    = s_q;
`ifdef SADD_COUT_EN
    assign bus.cout = cout_q;
`endif

endmodule

// File: tb/tb_serial_add5bit.sv
// Scoreboard bench for serial_add5bit: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_add5bit;
    localparam int unsigned WIDTH = 5;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        string            name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    serial_add5bit_if #(.WIDTH(WIDTH)) bus ();
    serial_add5bit #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_cmp     = 0;
    int   n_err     = 0;
    int   done_cnt  = 0;
    int   cyc       = 0;
    int   last_done = -1;
    bit   chk_spacing = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare every done pulse against the head of the scoreboard
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            exp_t e;
            done_cnt++;
            check("busy_with_done", 32'(bus.busy), 32'd0);
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
            end else begin
                e = q.pop_front();
                check({e.name, "_S"}, 32'(bus.S), 32'(e.s));
`ifdef SADD_COUT_EN
                check({e.name, "_cout"}, 32'(bus.cout), 32'(e.c));
`endif
            end
            if (chk_spacing && last_done >= 0)
                check("done_spacing", 32'(cyc - last_done), 32'd6);
            last_done = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one accepting edge
    task automatic launch(input logic [WIDTH-1:0] f, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] es, input logic ec,
                          input string name, input bit push);
        exp_t e;
        bus.F     = f;
        bus.B     = b;
        bus.start = 1'b1;
        if (push) begin
            e.s = es; e.c = ec; e.name = name;
            q.push_back(e);
        end
        tick();
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for all expected results to be observed
    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", q.size());
            q.delete();
        end
        tick();
    endtask

    initial begin
        #700000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        logic [WIDTH-1:0] fv;
        logic [WIDTH:0]   full;

        rst = 1'b1; bus.start = 1'b0; bus.F = '0; bus.B = '0;
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_S",    32'(bus.S),    32'd0);
`ifdef SADD_COUT_EN
        check("rst_cout", 32'(bus.cout), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Basic add with latency profile: busy after k..k+4, done after k+5
        launch(5'd3, 5'd2, 5'd5, 1'b0, "add3_2", 1'b1);
        check("lat_busy_k", 32'(bus.busy), 32'd1);
        check("lat_done_k", 32'(bus.done), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("lat_busy_mid", 32'(bus.busy), 32'd1);
            check("lat_done_mid", 32'(bus.done), 32'd0);
        end
        tick();
        check("lat_busy_end", 32'(bus.busy), 32'd0);
        check("lat_done_end", 32'(bus.done), 32'd1);
        drain();

        // Wraparound and zero cases
        launch(5'd31, 5'd1,  5'd0, 1'b1, "wrap31_1",  1'b1); drain();
        launch(5'd16, 5'd16, 5'd0, 1'b1, "wrap16_16", 1'b1); drain();
        launch(5'd0,  5'd0,  5'd0, 1'b0, "zero",      1'b1); drain();

        // start during SHIFT is ignored: one done, original result
        d0 = done_cnt;
        launch(5'd10, 5'd4, 5'd14, 1'b0, "ignore_start", 1'b1);
        tick(); tick();
        bus.F = 5'd1; bus.B = 5'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        drain();
        repeat (3) tick();
        check("one_done", 32'(done_cnt - d0), 32'd1);

        // Operand changes after the accepting edge have no effect
        launch(5'd12, 5'd9, 5'd21, 1'b0, "latched_ops", 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus.F = WIDTH'($urandom);
            bus.B = WIDTH'($urandom);
            tick();
        end
        drain();

        // Reset at the third SHIFT edge aborts without done
        d0 = done_cnt;
        launch(5'd20, 5'd20, 5'd0, 1'b0, "aborted", 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_S",    32'(bus.S),    32'd0);
`ifdef SADD_COUT_EN
        check("abort_cout", 32'(bus.cout), 32'd0);
`endif
        rst = 1'b0;
        repeat (8) tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        launch(5'd7, 5'd9, 5'd16, 1'b0, "after_abort", 1'b1);
        drain();

        // Inverse sweep, back-to-back with start held; garbage on F/B while shifting
        last_done   = -1;
        chk_spacing = 1'b1;
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                exp_t e;
                fv   = WIDTH'(a - b);
                full = (WIDTH+1)'(fv) + (WIDTH+1)'(b);
                bus.F = fv;
                bus.B = WIDTH'(b);
                bus.start = 1'b1;
                e.s = WIDTH'(a); e.c = full[WIDTH]; e.name = "inverse";
                q.push_back(e);
                tick();
                for (int i = 0; i < 5; i++) begin
                    bus.F = WIDTH'($urandom);
                    bus.B = WIDTH'($urandom);
                    tick();
                end
            end
        end
        bus.start = 1'b0;
        drain();
        chk_spacing = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_add5bit.md
# serial_add5bit

Bit-serial adder that reverses the 5-bit subtraction path: given a difference F and the subtrahend B, it reconstructs the minuend S = F + B (mod 2^WIDTH). It processes one bit per clock through a single full-adder slice and a carry flop, with a start/busy/done handshake. It sits downstream of the subtractor as its check/inverse path, and also acts as the area-minimal alternative to a ripple adder.

## Interface
- WIDTH, 5, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the block can accept a new operation
- F  input  WIDTH  addend (difference from subtractor); sampled on the accepting edge only
- B  input  WIDTH  addend (subtrahend); sampled on the accepting edge only
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: S is valid and final
- S  output  WIDTH  sum register; holds its value until the next accepted start
- cout  output  1  final carry out; present only with SADD_COUT_EN

One clock; reset is synchronous and active-high (clk, rst).

## Operation
- States: IDLE, SHIFT, DONE.
- A start is accepted when state is IDLE or DONE and start=1 at a rising edge.
- Accepting edge: latch F and B into shift registers, clear carry, clear bit counter, clear S, go to SHIFT.
- Each SHIFT edge, using bit i = counter, LSB first:
  - sum = F[i] ^ B[i] ^ c
  - c ← majority(F[i], B[i], c)
  - S shifts right with sum entering at the MSB.
  - Counter increments.
- After WIDTH SHIFT edges, S holds the full sum (bit 0 in S[0]). The state moves to DONE, and cout (if enabled) takes the final carry.
- DONE without start: the next edge goes to IDLE. DONE with start: accept, which gives back-to-back operation.
- start in SHIFT is ignored. It is not queued.
- F and B changes after the accepting edge have no effect.
- Arithmetic is unsigned modulo 2^WIDTH. Overflow wraps silently; only cout reports it.
- Counter width is clog2(WIDTH+1). The counter saturates logic-wise by leaving SHIFT at WIDTH, and never wraps inside an operation.

## Timing
- Reset values: state IDLE, busy=0, done=0, S=0, cout=0, carry=0, counter=0.
- rst has priority over start at any edge, including mid-SHIFT. The operation is aborted and no done is issued.
- Latency, with the start accepted at edge k:
  - busy=1 after edge k through edge k+WIDTH−1.
  - done=1 for exactly the cycle after edge k+WIDTH.
  - busy=0 in that cycle.
- Throughput: one result per WIDTH+1 cycles when start is held high.
- S changes during SHIFT and is meaningful only when done=1 or later while IDLE.
- done and busy are registered outputs, decoded from state flops only. They never go high together.

## Configuration
- SADD_COUT_EN defined:
  - The cout port exists.
  - cout is registered at the final SHIFT edge and holds until the next accepted start, which clears it to 0.
- SADD_COUT_EN undefined:
  - The cout port and the flop feeding it are absent.
  - The carry flop still exists internally.
  - All other behaviour is identical.

## Test plan
- Reset, then start with F=5'd3, B=5'd2 → busy high for 5 cycles, done pulses at edge k+5, S=5'd5, cout=0.
- Wrap: F=5'd31, B=5'd1 → S=5'd0, cout=1. Then F=5'd16, B=5'd16 → S=0, cout=1. Then F=0, B=0 → S=0, cout=0.
- Inverse check: for all 1024 (A,B) pairs, drive F=(A−B) mod 32 and B → S==A on every done. Hold start high to confirm back-to-back: done spacing is exactly 6 cycles.
- Start pulsed during SHIFT with different F/B → ignored; the in-flight result is unaffected and exactly one done is issued.
- Assert rst at the third SHIFT edge → next cycle is IDLE with all outputs 0 and no done. A fresh start with F=7, B=9 then yields S=16.
- Change F/B every cycle after the accepting edge → S reflects only the values latched on the accepting edge.
